// File: rtl/heap_run_guard_if.sv
// heap_run_guard_if: op stream, crash/arm status and range-buffer debug port of heap_run_guard
interface heap_run_guard_if #(
  parameter int ADDR_W = 32,
  parameter int NUM_TRK = 4,
  parameter int DEPTH = 8
);
  logic clr_i;
  logic valid_i;
  logic [1:0] op_i;
  logic [ADDR_W-1:0] addr_i;
  logic [3:0] size_i;
  logic [4:0] base_reg_i;
  logic en_crash_i;
  logic crash_o;
  logic armed_o;
  logic [NUM_TRK-1:0] active_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [$clog2(DEPTH)-1:0] rd_idx_i;
  logic [ADDR_W-1:0] rd_start_o;
  logic [ADDR_W-1:0] rd_end_o;
  modport master (
    output clr_i, valid_i, op_i, addr_i, size_i, base_reg_i, en_crash_i, rd_idx_i,
    input  crash_o, armed_o, active_o, count_o, rd_start_o, rd_end_o
  );
  modport slave (
    input  clr_i, valid_i, op_i, addr_i, size_i, base_reg_i, en_crash_i, rd_idx_i,
    output crash_o, armed_o, active_o, count_o, rd_start_o, rd_end_o
  );
endinterface

// File: rtl/heap_run_guard.sv
// heap_run_guard: tracks contiguous non-stack store runs, logs long ones, and turns a load hit plus JALR into a crash
module heap_run_guard #(
  parameter int ADDR_W = 32,
  parameter int NUM_TRK = 4,
  parameter int DEPTH = 8,
  parameter int MIN_RUN_BYTES = 32,
  parameter int TIMEOUT = 10
) (
  input logic clk_i,
  input logic rst_i,
  heap_run_guard_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = NUM_TRK > 1 ? $clog2(NUM_TRK) : 1;
  localparam logic [1:0] OP_ST = 2'd1;
  localparam logic [1:0] OP_LD = 2'd2;
  localparam logic [1:0] OP_JALR = 2'd3;
  logic [ADDR_W-1:0] t_start [NUM_TRK];
  logic [ADDR_W-1:0] t_next [NUM_TRK];
  logic [7:0] t_timer [NUM_TRK];
  logic [NUM_TRK-1:0] busy;
  logic [ADDR_W-1:0] b_start [DEPTH];
  logic [ADDR_W-1:0] b_end [DEPTH];
  logic [PW-1:0] wr_ptr, oldest, rp;
  logic [PW:0] count;
  logic pend, armed, crash;
  logic [ADDR_W-1:0] p_start, p_end, sz, cl_len;
  logic [ADDR_W:0] ext_sum;
  logic st, ext_any, idle_any, to_any, wrap, extend, load, close_st, close_to, log_run, hit, rd_ok;
  logic [TW-1:0] ext_idx, idle_idx, ev_idx, to_idx, sel, cl_idx;
  logic [7:0] ev_t;
  assign sz = ADDR_W'(bus.size_i);
  assign st = bus.valid_i && bus.op_i == OP_ST && bus.base_reg_i != 5'd2 && bus.base_reg_i != 5'd8 &&
              (bus.size_i == 4'd1 || bus.size_i == 4'd2 || bus.size_i == 4'd4 || bus.size_i == 4'd8);
  // descending scans leave the lowest matching index in each *_idx
  always_comb begin
    ext_any = 1'b0;
    ext_idx = '0;
    idle_any = 1'b0;
    idle_idx = '0;
    to_any = 1'b0;
    to_idx = '0;
    for (int i = NUM_TRK - 1; i >= 0; i--) begin
      if (busy[i] && t_next[i] == bus.addr_i) begin
        ext_any = 1'b1;
        ext_idx = TW'(i);
      end
      if (!busy[i]) begin
        idle_any = 1'b1;
        idle_idx = TW'(i);
      end
      if (busy[i] && t_timer[i] == 8'd0) begin
        to_any = 1'b1;
        to_idx = TW'(i);
      end
    end
    ev_idx = '0;
    ev_t = t_timer[0];
    for (int i = 1; i < NUM_TRK; i++)
      if (t_timer[i] < ev_t) begin
        ev_t = t_timer[i];
        ev_idx = TW'(i);
      end
  end
  assign ext_sum = {1'b0, t_next[ext_idx]} + {1'b0, sz};
  assign wrap = ext_sum[ADDR_W];
  assign extend = st && ext_any && !wrap;
  assign load = st && !extend;
  assign sel = ext_any ? ext_idx : idle_any ? idle_idx : ev_idx;
  assign close_st = st && (ext_any ? wrap : !idle_any);
  assign close_to = !st && to_any;
  assign cl_idx = st ? sel : to_idx;
  assign cl_len = t_next[cl_idx] - t_start[cl_idx];
  assign log_run = (close_st || close_to) && cl_len >= ADDR_W'(MIN_RUN_BYTES);
  assign oldest = wr_ptr - count[PW-1:0];
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < DEPTH; j++)
      if ({1'b0, PW'(j) - oldest} < count && b_start[j] <= bus.addr_i && bus.addr_i < b_end[j]) hit = 1'b1;
    for (int i = 0; i < NUM_TRK; i++)
      if (busy[i] && t_start[i] <= bus.addr_i && bus.addr_i < t_next[i]) hit = 1'b1;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy <= '0;
      wr_ptr <= '0;
      count <= '0;
      pend <= 1'b0;
      armed <= 1'b0;
      crash <= 1'b0;
    end else if (bus.clr_i) begin
      busy <= '0;
      wr_ptr <= '0;
      count <= '0;
      pend <= 1'b0;
      armed <= 1'b0;
      crash <= 1'b0;
    end else begin
      busy <= (busy & ~(close_to ? (NUM_TRK'(1) << to_idx) : '0)) | (load ? (NUM_TRK'(1) << sel) : '0);
      pend <= log_run;
      crash <= bus.valid_i && bus.op_i == OP_JALR && armed && bus.en_crash_i;
      armed <= !bus.valid_i ? armed : bus.op_i == OP_LD ? hit : bus.op_i == OP_JALR ? 1'b0 : armed;
      if (pend) begin
        wr_ptr <= wr_ptr + 1'b1;
        count <= count == (PW + 1)'(DEPTH) ? count : count + 1'b1;
      end
    end
  end
  // run payload and buffer contents are qualified by busy/pend/count, so they need no reset
  always_ff @(posedge clk_i) begin
    if (pend) begin
      b_start[wr_ptr] <= p_start;
      b_end[wr_ptr] <= p_end;
    end
    if (log_run) begin
      p_start <= t_start[cl_idx];
      p_end <= t_next[cl_idx];
    end
    for (int i = 0; i < NUM_TRK; i++)
      if (!st && t_timer[i] != 8'd0) t_timer[i] <= t_timer[i] - 8'd1;
    if (extend) begin
      t_next[sel] <= ext_sum[ADDR_W-1:0];
      t_timer[sel] <= 8'(TIMEOUT);
    end else if (load) begin
      t_start[sel] <= bus.addr_i;
      t_next[sel] <= bus.addr_i + sz;
      t_timer[sel] <= 8'(TIMEOUT);
    end
  end
  assign rp = oldest + bus.rd_idx_i;
  assign rd_ok = {1'b0, bus.rd_idx_i} < count;
  assign bus.rd_start_o = rd_ok ? b_start[rp] : '0;
  assign bus.rd_end_o = rd_ok ? b_end[rp] : '0;
  assign bus.crash_o = crash;
  assign bus.armed_o = armed;
  assign bus.active_o = busy;
  assign bus.count_o = count;
endmodule

// File: doc/heap_run_guard.md
Name: heap_run_guard

Overview:
Parametrised successor to the single-run heap overflow tracker in the execute stage. Tracks up to NUM_TRK concurrent contiguous store runs not based on sp/fp. Any run that closes with at least MIN_RUN_BYTES is logged into a circular range buffer. A load that reads from a logged or active range arms a flag, and the next JALR then raises a crash request that redirects the branch target.

Parameters:
ADDR_W, 32, address width
NUM_TRK, 4, concurrent run trackers
DEPTH, 8, range buffer entries (power of 2)
MIN_RUN_BYTES, 32, minimum run length (bytes) for logging
TIMEOUT, 10, idle non-store cycles before an active run closes (max 255)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clr_i  in  1  synchronous clear of trackers, buffer and flag
valid_i  in  1  op fields valid this cycle
op_i  in  2  0 other, 1 store, 2 load, 3 jalr
addr_i  in  ADDR_W  effective address (imm+rs1)
size_i  in  4  store size in bytes: 1, 2, 4 or 8
base_reg_i  in  5  rs1 index
en_crash_i  in  1  enables crash_o
crash_o  out  1  one-cycle crash request
armed_o  out  1  load-hit flag
active_o  out  NUM_TRK  tracker busy mask
count_o  out  $clog2(DEPTH)+1  valid buffer entries
rd_idx_i  in  $clog2(DEPTH)  debug read index, 0 = oldest
rd_start_o  out  ADDR_W  entry start (combinational)
rd_end_o  out  ADDR_W  entry end, exclusive (combinational)

Behaviour:
- Reset/clr: all trackers idle; buffer empty (wr_ptr=0, count=0); armed=0; crash_o=0. All outputs 0.
- Each tracker holds start, next (exclusive end), bytes, timer, busy.
- Tracked store: valid_i and op==1 and base_reg_i not in {2,8} and size in {1,2,4,8}. Other stores are ignored for tracking.
- Tracked store handling, in priority order:
  (a) If a busy tracker has next==addr_i, extend it (lowest index wins): next+=size, bytes+=size, timer=TIMEOUT.
  (b) Otherwise allocate the lowest-index idle tracker: start=addr, next=addr+size, bytes=size, timer=TIMEOUT.
  (c) If no tracker is idle, evict the busy tracker with the smallest timer (lowest index on ties). The evicted run is logged if it qualifies, and the tracker is reloaded as in (b) in the same cycle.
- Address wrap: if next+size would overflow ADDR_W, the run closes (logged if it qualifies) and the store starts a new run in that tracker.
- Timers: decrement only in cycles with no tracked store.
  - A busy tracker whose timer is 0 closes.
  - At most one closure per cycle: lowest index first; other expired trackers wait at 0.
- Logging: a run qualifies when bytes >= MIN_RUN_BYTES. It is written to buffer[wr_ptr] as {start, next} one cycle after closure, and wr_ptr increments.
  - When full (count==DEPTH), the oldest entry is overwritten and count stays at DEPTH.
  - Stores never close a run and push to the buffer in the same cycle as a timeout, so there is one push per cycle at most.
- Load (op==2) hit check: start <= addr_i < next against all valid buffer entries and all busy trackers. The check is combinational; armed sets on the next edge if it hits and clears if it misses.
- JALR (op==3):
  - crash_o=1 for exactly one cycle (edge t+1) if armed and en_crash_i.
  - armed clears at t+1 regardless.
  - Other ops leave armed unchanged.
- clr_i has priority over all ops in the same cycle.
- Asynchronous rst_i mid-run discards all state immediately.
- The read port returns the entry (wr_ptr - count + rd_idx) mod DEPTH. If rd_idx >= count, it returns 0.

Test Plan:
- 12 SW (size 4) with base x10 from 0x80001000, then 10 idle cycles → no log. Add an 11th idle cycle → next edge count_o=1 with rd_start=0x80001000 and rd_end=0x80001030.
- A contiguous run of 8 bytes followed by timeout → not logged, count_o stays 0. A run of 32 bytes → logged.
- 5 interleaved runs (NUM_TRK=4) at 0x1000/0x2000/0x3000/0x4000/0x5000, each 64 bytes → the tracker with the oldest timer is evicted and logged. active_o stays 4'hF.
- Log 9 qualifying runs with DEPTH=8 → count_o=8. rd_idx=0 returns the 2nd run; rd_idx=7 returns the 9th.
- LW at 0x80001010 after the first scenario, then JALR with en_crash_i=1 → armed_o=1, then crash_o pulses one cycle. Repeat with en_crash_i=0 → no pulse, armed clears.
- Stores with base x2 or x8 → active_o stays 0. clr_i or asynchronous rst_i asserted mid-run → all state returns to reset values.
